// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO controllers: Gray/binary pointer
// conversion and the read-side FWFT state encoding.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_e;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchronizer for Gray-coded pointers crossing clock domains.
module fifo_sync #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stage_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: pointer sync, empty/level flags,
// RAM read sequencing in standard or first-word-fall-through mode.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned AW          = 5,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_LEVEL    = 4,
    parameter int unsigned FWFT        = 1
) (
    input  logic          arst,
    input  logic          rclk,
    input  logic [AW:0]   wptr_gray,
    input  logic          ren,
    input  logic          clr_err,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    output logic [AW:0]   rptr_gray,
    output logic [DW-1:0] dout,
    output logic          rvalid,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   rlevel,
    output logic          underflow
);

    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wgray_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] level_next;
    logic          empty_i;
    logic          fsm_rd;
    logic          rd_fire;
    logic          underflow_set;
    logic [DW-1:0] dout_q;
    rd_state_e     state;
    rd_state_e     state_next;

    fifo_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk  (rclk),
        .arst (arst),
        .d    (wptr_gray),
        .q    (wgray_s)
    );

    assign wbin_s     = PW'(gray2bin(PTR_MAX_W'(wgray_s)));
    assign rbin_next  = rbin + PW'(rd_fire);
    assign rgray_next = PW'(bin2gray(PTR_MAX_W'(rbin_next)));
    assign level_next = wbin_s - rbin_next;

    // FWFT prefetch sequencing; held in IDLE when running in standard mode.
    always_comb begin
        state_next = state;
        fsm_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_i) begin
                    fsm_rd     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = HOLD;
            HOLD: begin
                if (ren) begin
                    if (!empty_i) begin
                        fsm_rd     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (FWFT == 0) begin
            state_next = IDLE;
            fsm_rd     = 1'b0;
        end
    end

    assign rd_fire       = (FWFT != 0) ? fsm_rd : (ren && !empty_i);
    assign mem_ren       = rd_fire;
    assign mem_raddr     = rbin[AW-1:0];
    assign empty         = (FWFT != 0) ? !rvalid : empty_i;
    assign underflow_set = ren && empty;
    assign dout          = (FWFT == 0 && rvalid) ? mem_rdata : dout_q;

    // Pointer and flag registers; empty_i and rlevel reflect the post-edge rbin.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            empty_i      <= 1'b1;
            rlevel       <= '0;
            almost_empty <= 1'b1;
        end else begin
            rbin         <= rbin_next;
            rptr_gray    <= rgray_next;
            empty_i      <= (rgray_next == wgray_s);
            rlevel       <= level_next;
            almost_empty <= (PTR_MAX_W'(level_next) <= AE_LEVEL);
        end
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            dout_q <= '0;
        end else begin
            state <= state_next;
            if (FWFT != 0) begin
                rvalid <= (state_next == HOLD);
                if (state == FETCH) begin
                    dout_q <= mem_rdata;
                end
            end else begin
                rvalid <= rd_fire;
                if (rvalid) begin
                    dout_q <= mem_rdata;
                end
            end
        end
    end

    // A new underflow takes priority over a simultaneous clear.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            underflow <= 1'b0;
        end else if (underflow_set) begin
            underflow <= 1'b1;
        end else if (clr_err) begin
            underflow <= 1'b0;
        end
    end

endmodule
